avalon_dm_cache: RTL
====================

// Module: avalon_dm_cache
// PURPOSE
// Direct-mapped, write-through, no-write-allocate cache between mips_cpu_bus (Avalon-MM master) and main memory.
// Presents an Avalon-MM slave port to the CPU and an Avalon-MM master port to memory.
// Read hits complete with zero wait states. Misses and all writes are forwarded to memory, with waitrequest passed back.
// The CPU's multicycle FSM sees fewer stalled FETCH/EXEC cycles; no CPU change is needed.
// PARAMETERS
// LINES      16  number of one-word lines; power of two, >=2; IDX_W = $clog2(LINES)
// CNT_W      16  width of hit/miss statistics counters
// PORTS
// clk            in   1      single clock, all state on posedge
// reset          in   1      asynchronous, active-high
// s_address      in   32     CPU word address (bits [1:0] ignored)
// s_read         in   1      CPU read request, held until s_waitrequest low
// s_write        in   1      CPU write request, held until s_waitrequest low
// s_writedata    in   32     CPU write data
// s_byteenable   in   4      CPU byte lanes
// s_waitrequest  out  1      stall to CPU
// s_readdata     out  32     read data to CPU
// m_address      out  32     memory address, {s_address[31:2],2'b00}
// m_read         out  1      memory read
// m_write        out  1      memory write
// m_writedata    out  32     = s_writedata
// m_byteenable   out  4      4'hF on reads, s_byteenable on writes
// m_waitrequest  in   1      memory stall
// m_readdata     in   32     valid in the cycle m_read=1 and m_waitrequest=0
// flush          in   1      invalidate all lines
// hit_count      out  CNT_W  saturating read-hit counter
// miss_count     out  CNT_W  saturating read-miss counter
// BEHAVIOUR
// - Address split: index=s_address[IDX_W+1:2]; tag=s_address[31:IDX_W+2]. Each line holds a valid bit, a tag and a 32-bit word.
// - Reset (async): all valid=0, state=IDLE, counters=0, s_readdata=0. m_read=m_write=0 and s_waitrequest=1 while reset is high.
// - FSM states: IDLE, FILL, WRITE.
// - IDLE:
//   - s_write=1 -> WRITE. s_write has priority if s_read and s_write are both high; that case is illegal but defined.
//   - s_read=1 and hit -> s_waitrequest=0 in the same cycle, combinationally. s_readdata = line data. hit_count++. Stay in IDLE.
//   - s_read=1 and miss -> s_waitrequest=1. Enter FILL next cycle. miss_count++, counted once per miss.
//   - No request -> s_waitrequest=1. No memory activity.
// - FILL:
//   - m_read=1 and m_address are held until m_waitrequest=0.
//   - In that cycle: s_waitrequest=0 and s_readdata=m_readdata (comb).
//   - At the clock edge: the line is written with data=m_readdata, tag and valid=1; return to IDLE.
// - WRITE:
//   - m_write=1 and the request is forwarded unchanged.
//   - s_waitrequest=0 in the cycle m_waitrequest=0; then return to IDLE.
//   - If the line hits, enabled bytes are merged into the line on that edge. On a miss the line is unchanged (no allocate).
// - s_readdata: in the accept cycle it carries the current read's data. Outside that cycle it holds the last accepted read's data.
//   A register is loaded on every read accept.
// - Latency: hit 0 wait cycles. Miss = 1 + memory wait cycles. Write = 1 + memory wait cycles.
// - flush: sampled only in IDLE with no accepted request. It clears all valid bits on that edge.
//   If asserted in FILL/WRITE it is ignored; the requester holds it high until the cache is idle. flush=1 blocks new IDLE accepts that cycle.
// - Counters saturate at all-ones; no wrap.
// - s_read/s_write dropping while in FILL/WRITE is a protocol violation. The transaction still completes to memory.
// - Reset mid-FILL/WRITE: the memory request is dropped immediately. A partially filled line is never marked valid.
// STRUCTURE
// - Shared package cache_pkg: state enum cache_state_t {IDLE,FILL,WRITE} and a byte-merge function merge_be(old,new,be).
// - Sub-module cache_line_store: valid/tag/data arrays, comb read port, one write port with byte enables, and a clear-all input.
//   Valid bits use async reset; tag/data arrays have no reset.
// - Top: FSM, hit compare, readdata hold register, counters, master-port muxing.
// TESTING
// - Reset, then read 0xBFC00000; memory returns 0x3C021234 after 2 waits -> s_waitrequest low on cycle 3, s_readdata=0x3C021234, miss_count=1.
// - Re-read 0xBFC00000 -> accepted same cycle, m_read never asserted, hit_count=1, data 0x3C021234.
// - Write 0xBFC00000 data 0x000000AB be=4'b0001 -> m_write with same fields; a later read hits and returns 0x3C0212AB.
// - Conflict: read 0x00000040 then 0x00000080 (LINES=16, same index) -> both miss; the 2nd evicts the 1st; a re-read of 0x40 misses.
// - Flush in IDLE after a cached read of 0x10, then read 0x10 -> miss, m_read asserted. Flush during FILL is ignored.
// - Assert reset during FILL with m_waitrequest high -> m_read drops immediately; a post-reset read of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for one-word lines: combinational read port,
// single byte-enabled write port, and a clear-all for flushing.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Valid bits: cleared by reset or flush, set when a line is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= merge_be(data_q[wr_idx], wr_data, wr_be);
    end
  end

endmodule

// File: rtl/avalon_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between an
// Avalon-MM CPU master and main memory. Read hits complete with zero
// wait states; misses and all writes go to memory.
module avalon_dm_cache
  import cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  input  logic [3:0]       s_byteenable,
  output logic             s_waitrequest,
  output logic [31:0]      s_readdata,
  output logic [31:0]      m_address,
  output logic             m_read,
  output logic             m_write,
  output logic [31:0]      m_writedata,
  output logic [3:0]       m_byteenable,
  input  logic             m_waitrequest,
  input  logic [31:0]      m_readdata,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  cache_state_t     state_q;
  logic             m_read_q;
  logic             m_write_q;
  logic [29:0]      req_addr_q;
  logic [31:0]      req_wdata_q;
  logic [3:0]       req_be_q;
  logic [31:0]      rd_hold_q;
  logic [CNT_W-1:0] hit_count_q;
  logic [CNT_W-1:0] miss_count_q;

  logic             idle;
  logic [29:0]      lk_addr;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             hit;
  logic             start_write;
  logic             start_read;
  logic             rd_hit_acc;
  logic             rd_miss;
  logic             fill_done;
  logic             write_done;
  logic             st_wr_en;
  logic [31:0]      st_wr_data;
  logic [3:0]       st_wr_be;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^s_address[1:0];

  // In IDLE the lookup follows the live CPU address; once a transaction
  // is underway it uses the address captured at acceptance.
  assign idle    = (state_q == IDLE);
  assign lk_addr = idle ? s_address[31:2] : req_addr_q;
  assign lk_idx  = lk_addr[IDX_W-1:0];
  assign lk_tag  = lk_addr[29:IDX_W];
  assign hit     = line_valid && (line_tag == lk_tag);

  // flush blocks every new accept in IDLE.
  assign start_write = idle && !flush && s_write;
  assign start_read  = idle && !flush && s_read && !s_write;
  assign rd_hit_acc  = start_read && hit;
  assign rd_miss     = start_read && !hit;
  assign fill_done   = (state_q == FILL)  && !m_waitrequest;
  assign write_done  = (state_q == WRITE) && !m_waitrequest;

  assign s_waitrequest = reset || !(rd_hit_acc || fill_done || write_done);
  assign s_readdata    = rd_hit_acc ? line_data :
                         fill_done  ? m_readdata : rd_hold_q;

  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_address    = {lk_addr, 2'b00};
  assign m_writedata  = idle ? s_writedata : req_wdata_q;
  assign m_byteenable = m_write_q ? req_be_q : 4'hF;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // A fill writes the full word; a write hit merges only enabled bytes.
  assign st_wr_en   = fill_done || (write_done && hit);
  assign st_wr_data = fill_done ? m_readdata : req_wdata_q;
  assign st_wr_be   = fill_done ? 4'hF : req_be_q;

  cache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .clear_all (idle && flush),
    .rd_idx    (lk_idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (st_wr_en),
    .wr_idx    (lk_idx),
    .wr_tag    (lk_tag),
    .wr_data   (st_wr_data),
    .wr_be     (st_wr_be)
  );

  // Transaction FSM: captures the request on entry and owns the
  // registered memory strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_write) begin
            state_q     <= WRITE;
            m_write_q   <= 1'b1;
            req_addr_q  <= s_address[31:2];
            req_wdata_q <= s_writedata;
            req_be_q    <= s_byteenable;
          end else if (rd_miss) begin
            state_q     <= FILL;
            m_read_q    <= 1'b1;
            req_addr_q  <= s_address[31:2];
          end
        end
        FILL: begin
          if (!m_waitrequest) begin
            state_q  <= IDLE;
            m_read_q <= 1'b0;
          end
        end
        WRITE: begin
          if (!m_waitrequest) begin
            state_q   <= IDLE;
            m_write_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-data hold register, reloaded on every accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hold_q <= '0;
    end else if (rd_hit_acc || fill_done) begin
      rd_hold_q <= s_readdata;
    end
  end

  // Saturating hit/miss statistics; a miss counts once, on leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (rd_hit_acc && (hit_count_q != '1))
        hit_count_q <= hit_count_q + CNT_W'(1);
      if (rd_miss && (miss_count_q != '1))
        miss_count_q <= miss_count_q + CNT_W'(1);
    end
  end

endmodule
